// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared saturating ALU.
// One operation is in flight at a time; the ALU result is captured one cycle
// after accept and then held as a response until the consumer takes it.
//
//   state | meaning
//   IDLE  | waiting for a request, grant is offered combinationally
//   EXEC  | operands presented to the ALU, result captured at end of cycle
//   RESP  | response held on rsp_* until rsp_rdy is sampled high
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_vld,
  input  logic [15:0] req0_src0,
  input  logic [15:0] req0_src1,
  input  logic [2:0]  req0_ctrl,
  input  logic [3:0]  req0_shamt,
  output logic        req0_rdy,

  input  logic        req1_vld,
  input  logic [15:0] req1_src0,
  input  logic [15:0] req1_src1,
  input  logic [2:0]  req1_ctrl,
  input  logic [3:0]  req1_shamt,
  output logic        req1_rdy,

  output logic [15:0] alu_src0,
  output logic [15:0] alu_src1,
  output logic [2:0]  alu_ctrl,
  output logic [3:0]  alu_shamt,
  input  logic [15:0] alu_result,
  input  logic        alu_ov,
  input  logic        alu_zr,
  input  logic        alu_ne,

  output logic        rsp_vld,
  output logic        rsp_id,
  input  logic        rsp_rdy,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_flags,

  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        last_grant;
  logic        gnt_vld;
  logic        gnt_id;
  logic        cnt_inc;

  logic [15:0] op_src0;
  logic [15:0] op_src1;
  logic [2:0]  op_ctrl;
  logic [3:0]  op_shamt;
  logic        op_id;

  logic [15:0] sel_src0;
  logic [15:0] sel_src1;
  logic [2:0]  sel_ctrl;
  logic [3:0]  sel_shamt;

  // The ALU only ever sees the captured operation, never a live request.
  assign alu_src0  = op_src0;
  assign alu_src1  = op_src1;
  assign alu_ctrl  = op_ctrl;
  assign alu_shamt = op_shamt;

  // Operand mux for the granted requester.
  always_comb begin
    sel_src0  = req0_src0;
    sel_src1  = req0_src1;
    sel_ctrl  = req0_ctrl;
    sel_shamt = req0_shamt;
    if (gnt_id) begin
      sel_src0  = req1_src0;
      sel_src1  = req1_src1;
      sel_ctrl  = req1_ctrl;
      sel_shamt = req1_shamt;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, arbitration and handshake outputs. A grant is only offered
  // in IDLE and never while reset is asserted; on a tie the requester that
  // did not win last time is chosen.
  always_comb begin
    state_nxt = state;
    gnt_vld   = 1'b0;
    gnt_id    = 1'b0;
    req0_rdy  = 1'b0;
    req1_rdy  = 1'b0;
    rsp_vld   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (req0_vld && req1_vld) begin
            gnt_vld = 1'b1;
            gnt_id  = ~last_grant;
          end else if (req0_vld) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
          end else if (req1_vld) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
          end
        end
        req0_rdy = gnt_vld & ~gnt_id;
        req1_rdy = gnt_vld &  gnt_id;
        if (gnt_vld) state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp_vld = 1'b1;
        if (rsp_rdy) begin
          cnt_inc   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Capture the granted operation and remember who won; held otherwise so a
  // requester that drops vld before being granted leaves no trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_src0    <= 16'h0000;
      op_src1    <= 16'h0000;
      op_ctrl    <= 3'b000;
      op_shamt   <= 4'h0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
    end else if (gnt_vld) begin
      op_src0    <= sel_src0;
      op_src1    <= sel_src1;
      op_ctrl    <= sel_ctrl;
      op_shamt   <= sel_shamt;
      op_id      <= gnt_id;
      last_grant <= gnt_id;
    end
  end

  // Response registers load only at the end of EXEC, so they stay frozen
  // for the whole RESP backpressure window.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result <= 16'h0000;
      rsp_flags  <= 3'b000;
      rsp_id     <= 1'b0;
    end else if (state == EXEC) begin
      rsp_result <= alu_result;
      rsp_flags  <= {alu_ov, alu_zr, alu_ne};
      rsp_id     <= op_id;
    end
  end

  // Completed-response counter, wrapping naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)          op_count <= 16'h0000;
    else if (cnt_inc) op_count <= op_count + 16'h0001;
  end

endmodule
